// File: rtl/pu_pkg.sv
// Shared types and sizing for the PU source-gather path.
package pu_pkg;

  localparam int unsigned PU_NSRC      = 20;
  localparam int unsigned PU_SRC_NBITS = 5;
  localparam int unsigned PU_DATA_W    = 32;

  typedef logic [PU_DATA_W-1:0] pu_desc_t;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } gather_st_e;

endpackage

// File: rtl/pu_src_slot.sv
// Single-descriptor holding register with a full flag; accepts only while empty.
module pu_src_slot #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [DataW-1:0] data_i,
  output logic             full_o,
  output logic [DataW-1:0] data_o
);

  logic             full_q, full_d;
  logic [DataW-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/pu_src_gather20.sv
// Per-source ingress slots feeding a 20-way arbiter; the granted descriptor moves
// into one valid/ready output register.
module pu_src_gather20
  import pu_pkg::*;
#(
  parameter int unsigned NUM_SRC   = PU_NSRC,
  parameter int unsigned SRC_NBITS = PU_SRC_NBITS,
  parameter int unsigned DATA_W    = PU_DATA_W,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        in_valid,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  output logic [NUM_SRC-1:0]        in_ready,
  output logic [NUM_SRC-1:0]        arb_req,
  output logic                      arb_en,
  input  logic [SRC_NBITS-1:0]      arb_sel,
  input  logic                      arb_gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_NBITS-1:0]      out_src,
  output logic [CNT_W-1:0]          fwd_cnt,
  output logic                      err
);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] clr;
  logic [DATA_W-1:0]  slot_data [NUM_SRC];

  gather_st_e          st_q, st_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SRC_NBITS-1:0] out_src_q, out_src_d;
  logic [CNT_W-1:0]    fwd_cnt_q, fwd_cnt_d;
  logic                err_q, err_d;

  logic sel_ok, grant_ok, ospace, pop;

  assign sel_ok   = 32'(arb_sel) < NUM_SRC;
  assign grant_ok = (st_q == WAIT) && arb_gnt && sel_ok;
  assign pop      = out_valid_q && out_ready;
  assign ospace   = !out_valid_q || out_ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    assign clr[i] = grant_ok && (arb_sel == SRC_NBITS'(i));
    pu_src_slot #(
      .DataW (DATA_W)
    ) u_slot (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (in_valid[i]),
      .clr_i  (clr[i]),
      .data_i (in_data[i*DATA_W +: DATA_W]),
      .full_o (full[i]),
      .data_o (slot_data[i])
    );
  end

  assign in_ready = ~full;
  assign arb_req  = full;

  // One request per two cycles keeps arb_req stable across the arbiter's latency.
  always_comb begin
    st_d   = st_q;
    arb_en = 1'b0;
    err_d  = err_q;
    unique case (st_q)
      IDLE: begin
        arb_en = (|full) && ospace;
        if (arb_en) st_d = WAIT;
        if (arb_gnt) err_d = 1'b1;
      end
      WAIT: begin
        st_d = IDLE;
        if (!(arb_gnt && sel_ok)) err_d = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  // A grant only lands after IDLE saw ospace, so a load never overwrites a live output.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (grant_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = slot_data[arb_sel];
      out_src_d   = arb_sel;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    fwd_cnt_d = fwd_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      fwd_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      fwd_cnt_q   <= fwd_cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pu_src_gather20.sv
// Directed bench for pu_src_gather20: scoreboard of expected descriptors checked by a
// monitor on every output handshake, plus direct checks of control and status outputs.
module tb_pu_src_gather20;
  import pu_pkg::*;

  localparam int N  = 20;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready, arb_req;
  logic            arb_en;
  logic [4:0]      arb_sel = '0;
  logic            arb_gnt = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [4:0]      out_src;
  logic [15:0]     fwd_cnt;
  logic            err;

  logic bad_sel = 1'b0;
  logic inject_gnt = 1'b0;

  typedef struct packed {
    logic [4:0] src;
    pu_desc_t   data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  pu_src_gather20 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .arb_req   (arb_req),
    .arb_en    (arb_en),
    .arb_sel   (arb_sel),
    .arb_gnt   (arb_gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .fwd_cnt   (fwd_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lowest(input logic [N-1:0] r);
    logic [4:0] s = '0;
    for (int i = N - 1; i >= 0; i--) if (r[i]) s = 5'(i);
    return s;
  endfunction

  // Arbiter stub: one-cycle latency, lowest index wins; can force a bad index.
  always @(posedge clk) begin
    arb_gnt <= arb_en | inject_gnt;
    arb_sel <= bad_sel ? 5'd20 : lowest(arb_req);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got src %0d data %0h expected none", out_src, out_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_src", 64'(out_src), 64'(mon_e.src));
        chk("out_data", 64'(out_data), 64'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int i, input logic [31:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic expect_out(input int s, input logic [31:0] d);
    exp_t e;
    e.src  = 5'(s);
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = '0;
    out_ready  = 1'b0;
    bad_sel    = 1'b0;
    inject_gnt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input logic [15:0] exp, input int budget);
    int n = 0;
    while (fwd_cnt !== exp && n < budget) begin
      step();
      n++;
    end
    chk("fwd_cnt_wait", 64'(fwd_cnt), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'hFFFFF);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_src", 64'(out_src), 0);
    chk("rst_fwd_cnt", 64'(fwd_cnt), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_arb_en", 64'(arb_en), 0);

    // Single descriptor through source 5
    set_desc(5, 32'hA5A5_0005);
    expect_out(5, 32'hA5A5_0005);
    in_valid = 20'h00020;
    step();
    in_valid = '0;
    chk("t1_in_ready", 64'(in_ready), 64'hFFFDF);
    chk("t1_arb_req", 64'(arb_req), 64'h00020);
    chk("t1_arb_en_idle", 64'(arb_en), 1);
    step();
    chk("t1_arb_en_wait", 64'(arb_en), 0);
    step();
    chk("t1_out_valid", 64'(out_valid), 1);
    chk("t1_out_data", 64'(out_data), 64'hA5A5_0005);
    chk("t1_out_src", 64'(out_src), 5);
    chk("t1_in_ready_free", 64'(in_ready), 64'hFFFFF);
    out_ready = 1'b1;
    step();
    chk("t1_fwd_cnt", 64'(fwd_cnt), 1);
    chk("t1_out_valid_clr", 64'(out_valid), 0);

    // Slots 3 and 7 together, back-to-back grants
    do_reset();
    out_ready = 1'b1;
    set_desc(3, 32'h3333_0003);
    set_desc(7, 32'h7777_0007);
    expect_out(3, 32'h3333_0003);
    expect_out(7, 32'h7777_0007);
    in_valid = 20'h00088;
    step();
    in_valid = '0;
    chk("t2_arb_req", 64'(arb_req), 64'h00088);
    step();
    step();
    chk("t2_first_src", 64'(out_src), 3);
    chk("t2_first_valid", 64'(out_valid), 1);
    step();
    step();
    chk("t2_second_src", 64'(out_src), 7);
    chk("t2_second_valid", 64'(out_valid), 1);
    step();
    chk("t2_fwd_cnt", 64'(fwd_cnt), 2);
    chk("t2_out_valid", 64'(out_valid), 0);
    chk("t2_err", 64'(err), 0);

    // Back-pressure: slots 1,2,4 with downstream stalled
    do_reset();
    set_desc(1, 32'h1111_0001);
    set_desc(2, 32'h2222_0002);
    set_desc(4, 32'h4444_0004);
    expect_out(1, 32'h1111_0001);
    expect_out(2, 32'h2222_0002);
    expect_out(4, 32'h4444_0004);
    in_valid = 20'h00016;
    step();
    in_valid = '0;
    step();
    step();
    chk("t3_out_src", 64'(out_src), 1);
    chk("t3_out_valid", 64'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_arb_en", 64'(arb_en), 0);
      chk("t3_stall_data", 64'(out_data), 64'h1111_0001);
      step();
    end
    chk("t3_in_ready", 64'(in_ready), 64'hFFFEB);
    out_ready = 1'b1;
    wait_cnt(16'd3, 30);
    chk("t3_err", 64'(err), 0);

    // Out-of-range grant index
    do_reset();
    bad_sel = 1'b1;
    set_desc(6, 32'h6666_0006);
    in_valid = 20'h00040;
    step();
    in_valid = '0;
    step();
    step();
    chk("t4_err", 64'(err), 1);
    chk("t4_slot_kept", 64'(in_ready), 64'hFFFBF);
    chk("t4_out_valid", 64'(out_valid), 0);
    expect_out(6, 32'h6666_0006);
    bad_sel = 1'b0;
    out_ready = 1'b1;
    wait_cnt(16'd1, 20);
    chk("t4_err_sticky", 64'(err), 1);

    // Grant while idle
    do_reset();
    chk("t4b_err_cleared", 64'(err), 0);
    inject_gnt = 1'b1;
    step();
    inject_gnt = 1'b0;
    step();
    chk("t4b_idle_gnt_err", 64'(err), 1);
    chk("t4b_out_valid", 64'(out_valid), 0);

    // Reset during WAIT discards slot 9 and the pending grant
    do_reset();
    out_ready = 1'b1;
    set_desc(9, 32'h9999_0009);
    in_valid = 20'h00200;
    step();
    in_valid = '0;
    step();
    chk("t5_in_wait", 64'(arb_en), 0);
    rst_n = 1'b0;
    step();
    chk("t5_in_ready", 64'(in_ready), 64'hFFFFF);
    chk("t5_out_valid", 64'(out_valid), 0);
    chk("t5_err", 64'(err), 0);
    chk("t5_fwd_cnt", 64'(fwd_cnt), 0);
    rst_n = 1'b1;
    repeat (6) step();
    chk("t5_no_output", 64'(out_valid), 0);
    chk("t5_fwd_cnt_after", 64'(fwd_cnt), 0);

    // Counter wrap
    force dut.fwd_cnt_q = 16'hFFFF;
    #1;
    release dut.fwd_cnt_q;
    chk("t6_preload", 64'(fwd_cnt), 64'hFFFF);
    set_desc(0, 32'h0000_C0DE);
    expect_out(0, 32'h0000_C0DE);
    in_valid = 20'h00001;
    step();
    in_valid = '0;
    wait_cnt(16'h0000, 20);

    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pu_src_gather20.md
Name: pu_src_gather20

Overview:
- Per-source ingress stage that feeds the 20-way round-robin arbiter (rr_arb20) and consumes its grant.
- Holds one descriptor per source and presents the occupied-slot vector as the arbiter request.
- Drives the arbiter enable. On grant, moves the selected slot's descriptor into a single output register with a valid/ready handshake.
- Sits between the 20 PU request sources and the shared downstream descriptor consumer.

Parameters:
- NUM_SRC, 20, number of sources; must match the arbiter width.
- SRC_NBITS, 5, width of a source index.
- DATA_W, 32, descriptor width per source.
- CNT_W, 16, width of the forwarded-descriptor counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  NUM_SRC  per-source descriptor valid.
- in_data  input  NUM_SRC*DATA_W  per-source descriptors; source i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_SRC  per-source slot empty (accept).
- arb_req  output  NUM_SRC  request vector to arbiter.
- arb_en  output  1  arbiter enable.
- arb_sel  input  SRC_NBITS  arbiter selected index; meaningful only while arb_gnt=1.
- arb_gnt  input  1  arbiter grant; one cycle after arb_en.
- out_valid  output  1  output descriptor valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  forwarded descriptor.
- out_src  output  SRC_NBITS  source index of out_data.
- fwd_cnt  output  CNT_W  descriptors forwarded (out_valid&out_ready); wraps at 2^CNT_W.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (rst_n=0 at a clk edge): all slots empty; state IDLE; out_valid=0; out_data=0; out_src=0; fwd_cnt=0; err=0; arb_en=0.
  - in_ready is all-ones from the first cycle after reset.
  - Reset mid-grant discards the in-flight grant and all slot contents; no descriptor is emitted.
- Slot i:
  - in_ready[i] = ~full[i], combinational from state.
  - Load when in_valid[i]&in_ready[i]; stays full until granted.
  - A slot is never loaded and cleared in the same cycle, because a full slot rejects input.
  - arb_req = full, unmasked.
- Output space: ospace = ~out_valid | out_ready.
- FSM:
  - IDLE: arb_en = (|full) & ospace. If arb_en=1, go to WAIT.
  - WAIT: arb_en=0; always return to IDLE next cycle.
    - If arb_gnt=1 and arb_sel<NUM_SRC: copy slot[arb_sel] to out_data/out_src, set out_valid=1, clear full[arb_sel]. All take effect at the clock edge ending WAIT.
    - If arb_gnt=0, or arb_sel>=NUM_SRC: set err=1 (sticky until reset); no slot is cleared; out_valid unchanged.
- Throughput: at most one grant per 2 cycles; the arbiter sees a stable request vector across its 1-cycle latency.
- Output register:
  - out_valid clears on out_valid&out_ready unless reloaded on the same edge; a simultaneous pop and load yields the new descriptor.
  - out_data/out_src are held stable while out_valid&~out_ready.
- arb_gnt while in IDLE is ignored and sets err.
- fwd_cnt increments by 1 per accepted output and wraps 0xFFFF -> 0x0000.

Decomposition:
- Shared package pu_pkg:
  - PU_NSRC=20, PU_SRC_NBITS=5.
  - Descriptor typedef pu_desc_t (logic [DATA_W-1:0]).
  - FSM enum gather_st_e {IDLE, WAIT}.
- One sub-module: pu_src_slot (single-descriptor holding register with load/clear and full flag), instantiated NUM_SRC times in a generate loop.
- rr_arb20 is not instantiated inside this block; the two are connected at the parent level.

Test Plan:
- Reset, then in_valid[5]=1, data 0xA5A5_0005 for one cycle -> in_ready[5]=0 next cycle; arb_req=0x00020. IDLE->WAIT with arb_en pulsed 1 cycle; arbiter grants sel=5 -> out_valid=1, out_data=0xA5A5_0005, out_src=5; in_ready[5]=1 again.
- Load slots 3 and 7 simultaneously after reset, out_ready=1 -> outputs in order src 3, then src 7, two cycles apart; fwd_cnt=2; err=0.
- Load slots 1,2,4 with out_ready=0 -> exactly one descriptor (src 1) is captured. arb_en stays 0 while out_valid=1 and out_ready=0. out_data is held for 10 stall cycles. Raising out_ready drains src 2, then src 4.
- Arbiter stub returns arb_gnt=1 with arb_sel=20 in WAIT -> err=1; no slot cleared; out_valid unchanged. err stays 1 until rst_n=0.
- Assert rst_n=0 in the WAIT cycle with slot 9 full -> all in_ready=1, out_valid=0, err=0, fwd_cnt=0 the next cycle; no output produced.
- Preload fwd_cnt to 0xFFFF via 65535 transfers, or with a force -> next accepted output gives fwd_cnt=0x0000.
